// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-wide data memory.
// Performs byte/halfword extraction with sign/zero extension on loads,
// read-modify-write for SB/SH, and illegal-funct3 / misalignment / range checks.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_fault,
    output logic [31:0] Addr,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // First byte address past the end of memory (33 bits so it cannot wrap).
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_mis_q;
    logic        resp_fault_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] wdata_out_q;

    logic        illegal_d;
    logic        misaligned_d;
    logic        range_d;

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        if (f3[1:0] == 2'b00) begin
            case (lo)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (f3[1:0] == 2'b01) begin
            if (lo[1]) begin
                r[31:16] = wd[15:0];
            end else begin
                r[15:0] = wd[15:0];
            end
        end else begin
            r = wd;
        end
        return r;
    endfunction

    // Classify the incoming request; priority is applied where these are consumed.
    always_comb begin
        illegal_d    = 1'b0;
        misaligned_d = 1'b0;
        range_d      = 1'b0;
        if (req_write) begin
            illegal_d = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            illegal_d = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misaligned_d = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned_d = (req_addr[1:0] != 2'b00);
        end else begin
            misaligned_d = 1'b0;
        end
        range_d = ({1'b0, req_addr} >= ADDR_LIMIT);
    end

    // Request FSM with all memory-port and response outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            funct3_q     <= 3'd0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wdata_out_q  <= 32'd0;
        end else begin
            // Pulses and strobes default low; only the transitions below raise them.
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wdata_out_q  <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        if (illegal_d || range_d) begin
                            // Illegal funct3 wins over misalignment; range is checked last
                            // but also reports through the fault flag.
                            resp_fault_q <= illegal_d | ~misaligned_d;
                            resp_mis_q   <= ~illegal_d & misaligned_d;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (misaligned_d) begin
                            resp_mis_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
                            mem_write_q  <= 1'b1;
                            wdata_out_q  <= req_wdata;
                            state_q      <= S_WR;
                        end else begin
                            mem_read_q   <= 1'b1;
                            state_q      <= S_RD;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: begin
                    // The memory word is consumed directly at the end of the read cycle.
                    if (write_q) begin
                        mem_write_q  <= 1'b1;
                        wdata_out_q  <= merge_store(ReadData, wdata_q, funct3_q, addr_q[1:0]);
                        state_q      <= S_WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= extend_load(ReadData, funct3_q, addr_q[1:0]);
                        state_q      <= S_RESP;
                    end
                end
                S_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_fault      = resp_fault_q;
    assign Addr            = {addr_q[31:2], 2'b00};
    assign WriteData       = wdata_out_q;
    assign MemWrite        = mem_write_q;
    assign MemRead         = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
        .Addr(Addr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: combinational read, write on rising edge.
    assign ReadData = MemRead ? mem[Addr[11:2]] : 32'd0;
    always @(posedge clock) begin
        if (MemWrite) mem[Addr[11:2]] <= WriteData;
    end

    // Issue one request and observe until the response (bounded at 8 cycles).
    task automatic do_req(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic mis, output logic flt,
                          output int nrd, output int nwr,
                          output logic [31:0] wd, output logic [31:0] wa);
        lat = 0; rd = 32'd0; mis = 1'b0; flt = 1'b0;
        nrd = 0; nwr = 0; wd = 32'd0; wa = 32'd0;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_funct3 = f3;
        req_addr = a; req_wdata = d;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                wd = WriteData;
                wa = Addr;
            end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                mis = resp_misaligned;
                flt = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);
        checks++;
        if ({resp_valid, resp_rdata, resp_misaligned, resp_fault, Addr, WriteData, MemWrite, MemRead} !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b rdata=%h mis=%b flt=%b addr=%h wd=%h mw=%b mr=%b, want all 0",
                     resp_valid, resp_rdata, resp_misaligned, resp_fault, Addr, WriteData, MemWrite, MemRead);
        end
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || MemWrite !== 1'b0 || mem[16] !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b mw=%b mem16=%h, want 1 0 00000000", req_ready, MemWrite, mem[16]);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3_t [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad_t [5] = '{32'h14, 32'h17, 32'h16, 32'h14, 32'h14};
        logic [31:0] ex_t [5] = '{32'hFFFF_FFF3, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_82F3, 32'h8081_82F3};
        int lat, nrd, nwr;
        logic [31:0] rd, wd, wa;
        logic mis, flt;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3_t[i], ad_t[i], 32'd0, lat, rd, mis, flt, nrd, nwr, wd, wa);
            checks++;
            if (lat !== 2 || rd !== ex_t[i] || mis !== 1'b0 || flt !== 1'b0 || nrd !== 1 || nwr !== 0) begin
                errors++;
                $display("FAIL load_%0d: got lat=%0d rdata=%h mis=%b flt=%b reads=%0d writes=%0d, want lat=2 rdata=%h 0 0 1 0",
                         i, lat, rd, mis, flt, nrd, nwr, ex_t[i]);
            end
        end
    endtask

    task automatic test_store_rmw;
        int lat, nrd, nwr;
        logic [31:0] rd, wd, wa;
        logic mis, flt;
        do_req(1'b1, 3'b000, 32'h09, 32'h0000_00AB, lat, rd, mis, flt, nrd, nwr, wd, wa);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || wd !== 32'h1122_AB44 || wa !== 32'h08 || rd !== 32'd0 || mis !== 1'b0 || flt !== 1'b0) begin
            errors++;
            $display("FAIL sb_rmw: got lat=%0d reads=%0d writes=%0d wdata=%h waddr=%h rdata=%h, want 3 1 1 1122ab44 00000008 0",
                     lat, nrd, nwr, wd, wa, rd);
        end
        checks++;
        if (mem[2] !== 32'h1122_AB44) begin
            errors++;
            $display("FAIL sb_mem: got %h want 1122ab44", mem[2]);
        end
        do_req(1'b1, 3'b001, 32'h0A, 32'h1234_BEEF, lat, rd, mis, flt, nrd, nwr, wd, wa);
        checks++;
        if (lat !== 3 || mem[2] !== 32'hBEEF_AB44) begin
            errors++;
            $display("FAIL sh_rmw: got lat=%0d mem2=%h, want 3 beefab44", lat, mem[2]);
        end
    endtask

    task automatic test_sw;
        int lat, nrd, nwr;
        logic [31:0] rd, wd, wa;
        logic mis, flt;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, lat, rd, mis, flt, nrd, nwr, wd, wa);
        checks++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1 || wa !== 32'h100 || wd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw: got lat=%0d reads=%0d writes=%0d waddr=%h wdata=%h, want 2 0 1 00000100 deadbeef",
                     lat, nrd, nwr, wa, wd);
        end
        do_req(1'b0, 3'b010, 32'h100, 32'd0, lat, rd, mis, flt, nrd, nwr, wd, wa);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_readback: got lat=%0d rdata=%h, want 2 deadbeef", lat, rd);
        end
    endtask

    task automatic test_errors;
        logic        w_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad_t [5] = '{32'h102, 32'h0B, 32'h1000, 32'h14, 32'h20};
        logic        em_t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ef_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat, nrd, nwr;
        logic [31:0] rd, wd, wa;
        logic mis, flt;
        for (int i = 0; i < 5; i++) begin
            do_req(w_t[i], f3_t[i], ad_t[i], 32'hFFFF_FFFF, lat, rd, mis, flt, nrd, nwr, wd, wa);
            checks++;
            if (lat !== 1 || mis !== em_t[i] || flt !== ef_t[i] || rd !== 32'd0 || nrd !== 0 || nwr !== 0) begin
                errors++;
                $display("FAIL error_%0d: got lat=%0d mis=%b flt=%b rdata=%h reads=%0d writes=%0d, want 1 %b %b 0 0 0",
                         i, lat, mis, flt, rd, nrd, nwr, em_t[i], ef_t[i]);
            end
        end
        // Pulse must not linger: the cycle after the response is quiet.
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_pulse: got valid=%b flt=%b ready=%b, want 0 0 1", resp_valid, resp_fault, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] rdy_v;
        logic [4:0] rsp_v;
        logic [31:0] rd2;
        rdy_v = 5'd0; rsp_v = 5'd0; rd2 = 32'd0;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            rdy_v[c-1] = req_ready;
            rsp_v[c-1] = resp_valid;
            if (c == 5) rd2 = resp_rdata;
            if (c == 3) begin
                req_write = 1'b0; req_wdata = 32'd0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (rdy_v !== 5'b00100) begin
            errors++;
            $display("FAIL b2b_ready: got %b want 00100 (cycle1 at lsb)", rdy_v);
        end
        checks++;
        if (rsp_v !== 5'b10010 || rd2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_resp: got resp=%b rdata=%h want 10010 12345678", rsp_v, rd2);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int nresp;
        nresp = 0;
        mem[8] = 32'hCAFE_F00D;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wr: got MemWrite=%b want 1", MemWrite);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_mw_drop: got MemWrite=%b want 0", MemWrite);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid) nresp++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (resp_valid) nresp++;
        end
        checks++;
        if (mem[8] !== 32'hCAFE_F00D || nresp !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_result: got mem8=%h resp=%0d ready=%b want cafef00d 0 1", mem[8], nresp, req_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5] = 32'h8081_82F3;
        mem[2] = 32'h1122_3344;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; reset_n = 1'b0;
        test_reset();
        test_loads();
        test_store_rmw();
        test_sw();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data-memory interface: accepts RISC-V load/store requests from the execute stage and drives the memory port (Addr/WriteData/MemWrite/MemRead/ReadData).
- Memory is word-only (32-bit, word index = Addr>>2, combinational read while MemRead=1, write on posedge when MemWrite=1). This block therefore performs:
  - byte/halfword extraction with sign/zero extension on loads;
  - read-modify-write for SB/SH;
  - misalignment, illegal-funct3 and range checking.
- Sits between the execute stage and the data memory. Stalls the pipeline through req_ready.

Parameters:
MEM_WORDS, 1024, memory depth in 32-bit words; byte addresses >= MEM_WORDS*4 raise resp_fault.

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present; accepted when req_valid & req_ready on a rising edge
req_ready  output  1  high only in IDLE
req_write  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle pulse, request complete
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_misaligned  output  1  valid with resp_valid
resp_fault  output  1  valid with resp_valid; range error or illegal funct3
Addr  output  32  word-aligned byte address to memory, {addr_q[31:2],2'b00}
WriteData  output  32  word written to memory
MemWrite  output  1  memory write enable
MemRead  output  1  memory read enable

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; all registers 0.
  - resp_valid, resp_rdata, resp_misaligned, resp_fault, Addr, WriteData, MemWrite and MemRead are all 0.
  - Requests are ignored while reset_n=0.
- States: IDLE, RD, WR, RESP.
- IDLE, on acceptance:
  - Latch addr, wdata, funct3 and write.
  - Check order: illegal funct3 (load 011/110/111; store 1xx or 011) -> fault; else misaligned (half: addr[0]; word: addr[1:0]!=0) -> misaligned; else addr >= MEM_WORDS*4 -> fault.
  - Any error -> RESP with the flag set; no memory access occurs.
  - Valid LW/LB/LH/LBU/LHU or SB/SH -> RD.
  - Valid SW -> WR.
- RD (1 cycle):
  - MemRead=1; ReadData captured into word_q at the end of the cycle.
  - Next state: load -> RESP; SB/SH -> WR.
- WR (1 cycle):
  - MemWrite=1.
  - WriteData: SW = wdata. SB = word_q with byte lane addr[1:0] replaced by wdata[7:0]. SH = word_q with half lane addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP (1 cycle):
  - resp_valid=1; responses come from registers.
  - Loads: resp_rdata = selected lane of word_q. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - Next state: IDLE.
- Outside RD/WR, MemRead=0 and MemWrite=0. Addr holds addr_q in all states. WriteData is 0 outside WR.
- Latency, counted as the cycle in which resp_valid is high after the acceptance edge:
  - load: 2;
  - SW: 2;
  - SB/SH: 3;
  - error: 1.
- Back-to-back: req_ready returns high the cycle after RESP. A new request can be accepted on the edge ending the IDLE cycle that follows RESP.
- Response outputs are 1-cycle pulses; resp_rdata/flags return to 0 when resp_valid is low.
- Reset mid-operation:
  - Aborts immediately; MemWrite drops asynchronously, so no write happens on the next edge.
  - An aborted SB/SH leaves memory unchanged; no response is issued.
- Address wrap: no arithmetic on the address; top bits are only range-checked.

Test Plan:
- mem[5]=0x8081_82F3; LB addr 0x14 -> resp in cycle 2, rdata 0xFFFF_FFF3; LBU 0x17 -> 0x0000_0080; LH 0x16 -> 0xFFFF_8081; LHU 0x14 -> 0x0000_82F3; LW 0x14 -> 0x8081_82F3.
- mem[2]=0x1122_3344; SB addr 0x09 data 0xAB -> RD then WR, WriteData 0x1122_AB44, resp cycle 3; SH 0x0A data 0xBEEF -> mem[2]=0xBEEF_AB44.
- SW 0x100 data 0xDEAD_BEEF -> MemWrite high exactly one cycle with Addr 0x100, MemRead never high, resp cycle 2; LW 0x100 returns 0xDEAD_BEEF.
- LW 0x102, SH 0x0B -> resp cycle 1, misaligned=1, no MemRead/MemWrite; LW 0x1000 (MEM_WORDS=1024) -> fault=1; load funct3 011 -> fault=1.
- Back-to-back SW then LW held on req_valid -> req_ready low during RD/WR/RESP; second request accepted in the IDLE cycle after RESP; total 2 responses.
- Assert reset_n=0 during WR of an SB to 0x20 -> MemWrite falls immediately, mem[8] unchanged, no resp_valid, req_ready high after release.
